// File: rtl/piece_queue_controller.sv
// Preview queue and hold-slot controller between the tetromino generator and the game FSM.
// Refills the queue one generator pulse at a time and serves spawn/hold requests from IDLE.
module piece_queue_controller #(
  parameter int DEPTH = 3
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic [2:0]           gen_block_idx,
  output logic                 gen_new_block,
  input  logic                 flush,
  input  logic                 spawn_req,
  input  logic                 hold_req,
  output logic                 spawn_valid,
  output logic [2:0]           spawn_idx,
  output logic                 hold_reject,
  output logic [2:0]           hold_idx,
  output logic [3*DEPTH-1:0]   preview_idx,
  output logic                 queue_ready
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [2:0] NONE = 3'd7;

  typedef enum logic [1:0] {START, FILL_REQ, FILL_CAP, IDLE} state_t;

  state_t                state;
  logic [DEPTH-1:0][2:0] q;
  logic [CW-1:0]         count;
  logic [2:0]            active_idx;
  logic                  active_valid;
  logic                  hold_allowed;
  logic                  full;
  logic                  pop;

  assign preview_idx = q;
  assign full = (count == DEPTH_C);
  // Requests that consume the queue head: a spawn, or a hold into an empty slot.
  assign pop = spawn_req ||
               (hold_req && active_valid && hold_allowed && hold_idx == NONE);

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state         <= START;
      q             <= '1;
      count         <= '0;
      active_idx    <= NONE;
      active_valid  <= 1'b0;
      hold_allowed  <= 1'b0;
      gen_new_block <= 1'b0;
      spawn_valid   <= 1'b0;
      hold_reject   <= 1'b0;
      queue_ready   <= 1'b0;
      spawn_idx     <= NONE;
      hold_idx      <= NONE;
    end else begin
      gen_new_block <= 1'b0;
      spawn_valid   <= 1'b0;
      hold_reject   <= 1'b0;
      queue_ready   <= 1'b0;
      if (flush) begin
        q             <= '1;
        count         <= '0;
        hold_idx      <= NONE;
        spawn_idx     <= NONE;
        active_idx    <= NONE;
        active_valid  <= 1'b0;
        hold_allowed  <= 1'b0;
        state         <= FILL_REQ;
        gen_new_block <= 1'b1;
      end else begin
        case (state)
          START: begin
            state         <= FILL_REQ;
            gen_new_block <= 1'b1;
          end
          FILL_REQ: state <= FILL_CAP;
          FILL_CAP: begin
            q[count] <= (gen_block_idx == NONE) ? 3'd0 : gen_block_idx;
            count    <= count + CW'(1);
            if (count + CW'(1) == DEPTH_C) begin
              state       <= IDLE;
              queue_ready <= 1'b1;
            end else begin
              state         <= FILL_REQ;
              gen_new_block <= 1'b1;
            end
          end
          IDLE: begin
            queue_ready <= full;
            if (full && (spawn_req || hold_req)) begin
              if (pop) begin
                spawn_idx    <= q[0];
                spawn_valid  <= 1'b1;
                active_idx   <= q[0];
                active_valid <= 1'b1;
                for (int i = 0; i < DEPTH - 1; i++) q[i] <= q[i+1];
                q[DEPTH-1]   <= NONE;
                count        <= count - CW'(1);
                if (spawn_req) hold_allowed <= 1'b1;
                else begin
                  hold_idx     <= active_idx;
                  hold_allowed <= 1'b0;
                end
                state         <= FILL_REQ;
                gen_new_block <= 1'b1;
                queue_ready   <= 1'b0;
              end else if (!active_valid || !hold_allowed) begin
                hold_reject <= 1'b1;
              end else begin
                // Swap with a full hold slot; queue untouched, stay in IDLE.
                spawn_idx    <= hold_idx;
                spawn_valid  <= 1'b1;
                hold_idx     <= active_idx;
                active_idx   <= hold_idx;
                hold_allowed <= 1'b0;
              end
            end
          end
          default: state <= START;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_piece_queue_controller.sv
// Scoreboard bench for piece_queue_controller (DEPTH=3): stimulus pushes expected
// spawn/reject responses, a negedge monitor pops and compares on every pulse.
module tb_piece_queue_controller;
  logic       Clk = 1'b0;
  logic       Reset_n;
  logic [2:0] gen_block_idx;
  logic       gen_new_block;
  logic       flush, spawn_req, hold_req;
  logic       spawn_valid, hold_reject, queue_ready;
  logic [2:0] spawn_idx, hold_idx;
  logic [8:0] preview_idx;

  typedef struct {
    logic       rej;
    logic [2:0] sidx;
    logic [2:0] hidx;
    logic       gnb;
  } exp_t;

  exp_t       sb[$];
  logic [2:0] gen_q[$];
  int         checks = 0;
  int         errors = 0;
  int         n;

  piece_queue_controller #(.DEPTH(3)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .gen_block_idx(gen_block_idx),
    .gen_new_block(gen_new_block), .flush(flush), .spawn_req(spawn_req),
    .hold_req(hold_req), .spawn_valid(spawn_valid), .spawn_idx(spawn_idx),
    .hold_reject(hold_reject), .hold_idx(hold_idx), .preview_idx(preview_idx),
    .queue_ready(queue_ready)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Generator model: index appears the cycle after the request pulse.
  always @(posedge Clk) begin
    if (gen_new_block) begin
      #1;
      gen_block_idx = (gen_q.size() != 0) ? gen_q.pop_front() : 3'd5;
    end
  end

  // Monitor: every spawn_valid / hold_reject pulse must match the next expectation.
  always @(negedge Clk) begin
    if (Reset_n && (spawn_valid || hold_reject)) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", {spawn_valid, hold_reject}, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("pulse_reject", hold_reject, e.rej);
        chk("pulse_spawn_valid", spawn_valid, !e.rej);
        chk("pulse_spawn_idx", spawn_idx, e.sidx);
        chk("pulse_hold_idx", hold_idx, e.hidx);
        chk("pulse_gen_new_block", gen_new_block, e.gnb);
      end
    end
  end

  task automatic push_exp(input logic rej, input logic [2:0] s, input logic [2:0] h,
                          input logic g);
    exp_t e;
    e.rej = rej; e.sidx = s; e.hidx = h; e.gnb = g;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic wait_pulse(input string name, input int budget, output int cnt);
    cnt = 0;
    do begin tick(); cnt++; end while (!(spawn_valid || hold_reject) && cnt < budget);
    if (!(spawn_valid || hold_reject)) chk({name, "_timeout"}, 0, 1);
  endtask

  task automatic wait_ready(input string name, input int budget, output int cnt);
    cnt = 0;
    do begin tick(); cnt++; end while (!queue_ready && cnt < budget);
    if (!queue_ready) chk({name, "_timeout"}, 0, 1);
  endtask

  task automatic chk_reset_vals(input string name);
    chk({name, "_gnb"}, gen_new_block, 0);
    chk({name, "_spawn_valid"}, spawn_valid, 0);
    chk({name, "_hold_reject"}, hold_reject, 0);
    chk({name, "_queue_ready"}, queue_ready, 0);
    chk({name, "_spawn_idx"}, spawn_idx, 7);
    chk({name, "_hold_idx"}, hold_idx, 7);
    chk({name, "_preview"}, preview_idx, 9'h1FF);
  endtask

  initial begin
    Reset_n = 1'b0; flush = 1'b0; spawn_req = 1'b0; hold_req = 1'b0;
    gen_block_idx = 3'd0;
    repeat (2) @(posedge Clk);
    #1;
    chk_reset_vals("reset");

    // Reset fill: 4,2,6 -> ready 6 cycles after the first edge sampling Reset_n high.
    gen_q = '{3'd4, 3'd2, 3'd6};
    Reset_n = 1'b1;
    tick();
    chk("fill_first_gnb", gen_new_block, 1);
    wait_ready("fill", 20, n);
    chk("fill_ready_cycles", n, 6);
    chk("fill_preview", preview_idx, 9'h194);
    chk("fill_spawn_idx", spawn_idx, 7);
    chk("fill_hold_idx", hold_idx, 7);

    // Spawn and refill with 1.
    gen_q.push_back(3'd1);
    push_exp(1'b0, 3'd4, 3'd7, 1'b1);
    spawn_req = 1'b1;
    wait_pulse("spawn1", 10, n);
    spawn_req = 1'b0;
    chk("spawn1_latency", n, 1);
    chk("spawn1_ready_low", queue_ready, 0);
    wait_ready("refill1", 10, n);
    chk("refill1_cycles", n, 2);
    chk("refill1_preview", preview_idx, 9'h072);

    // Hold into empty slot (active 4), refill with 3, then lockout reject.
    gen_q.push_back(3'd3);
    push_exp(1'b0, 3'd2, 3'd4, 1'b1);
    hold_req = 1'b1;
    wait_pulse("hold_empty", 10, n);
    hold_req = 1'b0;
    chk("hold_empty_latency", n, 1);
    wait_ready("refill2", 10, n);
    chk("refill2_preview", preview_idx, 9'h0CE);
    push_exp(1'b1, 3'd2, 3'd4, 1'b0);
    hold_req = 1'b1;
    wait_pulse("hold_lock", 10, n);
    hold_req = 1'b0;
    chk("hold_lock_latency", n, 1);
    chk("hold_lock_preview", preview_idx, 9'h0CE);
    chk("hold_lock_ready", queue_ready, 1);

    // Normal spawn of 6, then hold swap with slot 4, then immediate lockout.
    gen_q.push_back(3'd3);
    push_exp(1'b0, 3'd6, 3'd4, 1'b1);
    spawn_req = 1'b1;
    wait_pulse("spawn2", 10, n);
    spawn_req = 1'b0;
    wait_ready("refill3", 10, n);
    chk("refill3_preview", preview_idx, 9'h0D9);
    push_exp(1'b0, 3'd4, 3'd6, 1'b0);
    hold_req = 1'b1;
    wait_pulse("swap", 10, n);
    chk("swap_preview", preview_idx, 9'h0D9);
    chk("swap_ready", queue_ready, 1);
    push_exp(1'b1, 3'd4, 3'd6, 1'b0);
    wait_pulse("swap_lock", 10, n);
    hold_req = 1'b0;
    chk("swap_lock_latency", n, 1);

    // Sentinel: generator 7 captured as 0.
    gen_q.push_back(3'd7);
    push_exp(1'b0, 3'd1, 3'd6, 1'b1);
    spawn_req = 1'b1;
    wait_pulse("spawn3", 10, n);
    spawn_req = 1'b0;
    wait_ready("refill4", 10, n);
    chk("sentinel_preview", preview_idx, 9'h01B);

    // Spawn and hold together: spawn first, then the held request swaps.
    gen_q.push_back(3'd5);
    push_exp(1'b0, 3'd3, 3'd6, 1'b1);
    push_exp(1'b0, 3'd6, 3'd3, 1'b0);
    spawn_req = 1'b1; hold_req = 1'b1;
    wait_pulse("both_spawn", 10, n);
    spawn_req = 1'b0;
    chk("both_spawn_latency", n, 1);
    wait_pulse("both_hold", 10, n);
    hold_req = 1'b0;
    chk("both_hold_latency", n, 3);
    chk("both_preview", preview_idx, 9'h143);

    // Flush with every request: no pulses, all cleared, refill from 0,1,2.
    gen_q = '{3'd0, 3'd1, 3'd2};
    flush = 1'b1; spawn_req = 1'b1; hold_req = 1'b1;
    tick();
    flush = 1'b0; spawn_req = 1'b0; hold_req = 1'b0;
    chk("flush_spawn_valid", spawn_valid, 0);
    chk("flush_hold_reject", hold_reject, 0);
    chk("flush_gnb", gen_new_block, 1);
    chk("flush_spawn_idx", spawn_idx, 7);
    chk("flush_hold_idx", hold_idx, 7);
    chk("flush_preview", preview_idx, 9'h1FF);
    chk("flush_ready", queue_ready, 0);
    wait_ready("flush_fill", 20, n);
    chk("flush_fill_cycles", n, 6);
    chk("flush_fill_preview", preview_idx, 9'h088);
    push_exp(1'b1, 3'd7, 3'd7, 1'b0);
    hold_req = 1'b1;
    wait_pulse("hold_no_active", 10, n);
    hold_req = 1'b0;

    // Reset during FILL_CAP: in-flight index 6 is discarded, fill restarts at slot 0.
    gen_q = '{3'd6};
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    Reset_n = 1'b0;
    tick();
    chk_reset_vals("midreset");
    gen_q = '{3'd5, 3'd4, 3'd3};
    Reset_n = 1'b1;
    tick();
    chk("midreset_first_gnb", gen_new_block, 1);
    wait_ready("midreset_fill", 20, n);
    chk("midreset_fill_cycles", n, 6);
    chk("midreset_preview", preview_idx, 9'h0E5);
    chk("midreset_hold_idx", hold_idx, 7);

    tick();
    chk("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
